// File: rtl/apb_master.sv
// APB master: accepts one command at a time, runs a single APB transfer with a
// bounded wait, and holds the response until the consumer accepts it.
module apb_master #(
   parameter int unsigned ADDR_W      = 33,
   parameter int unsigned DATA_W      = 33,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   // Abort decision is taken on the wait cycle that would bring the count to TIMEOUT_CYC.
   localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYC - 1);

   state_e            state_q, state_d;
   logic [7:0]        wait_q, wait_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              tout_q, tout_d;

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      tout_d   = tout_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               wait_d   = '0;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            state_d = StAccess;
         end
         StAccess: begin
            if (pready) begin
               rdata_d = pwrite_q ? '0 : prdata;
               err_d   = pslverr;
               tout_d  = 1'b0;
               state_d = StResp;
            end else if (wait_q == WaitLast) begin
               rdata_d = '0;
               err_d   = 1'b1;
               tout_d  = 1'b1;
               state_d = StResp;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q  <= StIdle;
         wait_q   <= '0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         tout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         tout_q   <= tout_d;
      end
   end

   // Held off while reset is asserted so no command is offered into a reset edge.
   assign cmd_ready   = (state_q == StIdle) && !prst;
   assign psel        = (state_q == StSetup) || (state_q == StAccess);
   assign penable     = (state_q == StAccess);
   assign rsp_valid   = (state_q == StResp);
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = tout_q;

endmodule
